// File: rtl/exmem_stage_reg.sv
// EX/MEM pipeline stage register with valid/ready handshake, flush and a saturating stall counter.
// Latency: 1 cycle from accept to out_valid. Builds with one slot by default; EXMEM_SKID_EN adds a skid slot.
// Backpressure: one slot gives in_ready = !out_valid || out_ready; skid mode gives registered in_ready = !skid_valid.
module exmem_stage_reg #(
    parameter int WB_W   = 2,
    parameter int M_W    = 3,
    parameter int DATA_W = 32,
    parameter int RD_W   = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WB_W-1:0]   wb_in,
    input  logic [M_W-1:0]    m_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [RD_W-1:0]   rdrt_in,
    input  logic              zero_in,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WB_W-1:0]   wb_out,
    output logic [M_W-1:0]    m_out,
    output logic [DATA_W-1:0] data_out,
    output logic [DATA_W-1:0] alu_out,
    output logic [RD_W-1:0]   rdrt_out,
    output logic              zero_out,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic [WB_W-1:0]   wb;
        logic [M_W-1:0]    m;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] alu;
        logic [RD_W-1:0]   rdrt;
        logic              zero;
    } ent_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    ent_t             in_dat;
    ent_t             main_q, main_d;
    logic             main_vld_q, main_vld_d;
    logic             push, pop;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    assign in_dat = {wb_in, m_in, data_in, alu_in, rdrt_in, zero_in};
    assign pop    = main_vld_q && out_ready;
    assign push   = in_valid && in_ready && !flush;

`ifdef EXMEM_SKID_EN
    ent_t skid_q, skid_d;
    logic skid_vld_q, skid_vld_d;
    logic in_ready_q, in_ready_d;

    assign in_ready = in_ready_q;

    // Two-entry ordering: skid always holds the younger entry and refills main when main leaves.
    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (pop) begin
            if (skid_vld_q) begin
                // push cannot coincide here: in_ready is low while skid is occupied
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end else begin
                main_vld_d = push;
                if (push) begin
                    main_d = in_dat;
                end
            end
        end else if (!main_vld_q) begin
            main_vld_d = push;
            if (push) begin
                main_d = in_dat;
            end
        end else if (push) begin
            skid_d     = in_dat;
            skid_vld_d = 1'b1;
        end
        in_ready_d = !skid_vld_d;
    end

    // Skid slot and registered ready; reset leaves the stage ready to accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
            in_ready_q <= in_ready_d;
        end
    end
`else
    assign in_ready = !main_vld_q || out_ready;

    // Single slot: a new entry replaces the leaving one, flush drops everything but keeps payload bits.
    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        if (flush) begin
            main_vld_d = 1'b0;
        end else if (push) begin
            main_d     = in_dat;
            main_vld_d = 1'b1;
        end else if (pop) begin
            main_vld_d = 1'b0;
        end
    end
`endif

    // Count cycles where a held entry is refused downstream; stick at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (main_vld_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
    end

    // Main slot and stall counter state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q      <= '0;
            main_vld_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            main_q      <= main_d;
            main_vld_q  <= main_vld_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Control fields are forced to a bubble when nothing is held; data fields just hold.
    assign out_valid = main_vld_q;
    assign wb_out    = main_vld_q ? main_q.wb : '0;
    assign m_out     = main_vld_q ? main_q.m  : '0;
    assign data_out  = main_q.data;
    assign alu_out   = main_q.alu;
    assign rdrt_out  = main_q.rdrt;
    assign zero_out  = main_q.zero;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_exmem_stage_reg.sv
// Bench for exmem_stage_reg: directed scenarios plus randomized traffic against a queue model.
// Two instances share stimulus: default widths and CNT_W=4 for counter saturation.
// Works in both buffering modes (EXMEM_SKID_EN defined or not).
module tb_exmem_stage_reg;

`ifdef EXMEM_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [31:0] d;
        logic [31:0] a;
        logic [4:0]  r;
        logic        z;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [1:0]  wb_in = '0;
    logic [2:0]  m_in = '0;
    logic [31:0] data_in = '0;
    logic [31:0] alu_in = '0;
    logic [4:0]  rdrt_in = '0;
    logic        zero_in = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, zero_out;
    logic [1:0]  wb_out;
    logic [2:0]  m_out;
    logic [31:0] data_out, alu_out;
    logic [4:0]  rdrt_out;
    logic [15:0] stall_cnt;

    logic        in_ready4, out_valid4, zero_out4;
    logic [1:0]  wb_out4;
    logic [2:0]  m_out4;
    logic [31:0] data_out4, alu_out4;
    logic [4:0]  rdrt_out4;
    logic [3:0]  stall_cnt4;

    always #5 clk = ~clk;

    exmem_stage_reg dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .wb_in(wb_in), .m_in(m_in), .data_in(data_in), .alu_in(alu_in),
        .rdrt_in(rdrt_in), .zero_in(zero_in), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .wb_out(wb_out), .m_out(m_out), .data_out(data_out), .alu_out(alu_out),
        .rdrt_out(rdrt_out), .zero_out(zero_out), .stall_cnt(stall_cnt)
    );

    exmem_stage_reg #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .wb_in(wb_in), .m_in(m_in), .data_in(data_in), .alu_in(alu_in),
        .rdrt_in(rdrt_in), .zero_in(zero_in), .flush(flush),
        .out_valid(out_valid4), .out_ready(out_ready),
        .wb_out(wb_out4), .m_out(m_out4), .data_out(data_out4), .alu_out(alu_out4),
        .rdrt_out(rdrt_out4), .zero_out(zero_out4), .stall_cnt(stall_cnt4)
    );

    int   n_checks = 0;
    int   n_errors = 0;

    // reference model: ordered list of held entries, last visible payload, stall counts
    ent_t        q[$];
    ent_t        hold = '0;
    int unsigned cnt16 = 0;
    int unsigned cnt4 = 0;
    bit          acc;
    bit          got_en = 1'b0;
    logic [31:0] got[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ent_t cur_in();
        return {wb_in, m_in, data_in, alu_in, rdrt_in, zero_in};
    endfunction

    function automatic logic [75:0] exp_vec();
        bit   vld;
        ent_t f;
        vld = (q.size() > 0);
        f   = vld ? q[0] : hold;
        return {vld, vld ? f.wb : 2'b00, vld ? f.m : 3'b000, f.d, f.a, f.r, f.z};
    endfunction

    // Compare every output against the model, then advance the model by one edge.
    task automatic tick();
        bit exp_rdy;
        @(negedge clk);
        exp_rdy = SKID ? (q.size() < 2) : (q.size() == 0 || out_ready);
        chk("in_ready", in_ready, exp_rdy);
        chk("in_ready_c4", in_ready4, exp_rdy);
        chk("outputs", {out_valid, wb_out, m_out, data_out, alu_out, rdrt_out, zero_out}, exp_vec());
        chk("outputs_c4", {out_valid4, wb_out4, m_out4, data_out4, alu_out4, rdrt_out4, zero_out4}, exp_vec());
        chk("stall_cnt", stall_cnt, cnt16);
        chk("stall_cnt_c4", stall_cnt4, cnt4);
        acc = in_valid && exp_rdy && !flush;
        if (got_en && out_valid && out_ready) got.push_back(alu_out);
        if (q.size() > 0 && !out_ready) begin
            if (cnt16 < 65535) cnt16++;
            if (cnt4 < 15) cnt4++;
        end
        if (flush) begin
            q.delete();
        end else begin
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (acc) q.push_back(cur_in());
        end
        if (q.size() > 0) hold = q[0];
        @(posedge clk);
        #1;
    endtask

    // Assert reset between edges and confirm outputs clear before the next edge.
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_outputs", {out_valid, wb_out, m_out, data_out, alu_out, rdrt_out, zero_out}, 76'd0);
        chk("rst_stall", stall_cnt, 16'd0);
        chk("rst_outputs_c4", {out_valid4, wb_out4, m_out4, data_out4, alu_out4, rdrt_out4, zero_out4}, 76'd0);
        chk("rst_stall_c4", stall_cnt4, 4'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        hold  = '0;
        cnt16 = 0;
        cnt4  = 0;
    endtask

    initial begin
        int idx;
        // reset state
        #1;
        chk("init_outputs", {out_valid, wb_out, m_out, data_out, alu_out, rdrt_out, zero_out}, 76'd0);
        chk("init_stall", stall_cnt, 16'd0);
        chk("init_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // one-cycle latency on an empty stage
        in_valid = 1'b1; alu_in = 32'h0000_1234; wb_in = 2'b11; m_in = 3'b000; out_ready = 1'b1;
        tick();
        chk("lat_valid", out_valid, 1'b1);
        chk("lat_alu", alu_out, 32'h0000_1234);
        chk("lat_wb", wb_out, 2'b11);
        in_valid = 1'b0;
        tick();
        chk("bubble_valid", out_valid, 1'b0);
        chk("bubble_wb", wb_out, 2'b00);
        chk("bubble_alu_hold", alu_out, 32'h0000_1234);

        // fill and stall
        out_ready = 1'b0; in_valid = 1'b1; alu_in = 32'hCAFE_0001; m_in = 3'b101; wb_in = 2'b01;
        tick();
        alu_in = 32'hCAFE_0002; m_in = 3'b010;
        tick();
        in_valid = 1'b0;
        chk("stall_start", stall_cnt, 16'd1);
        repeat (5) tick();
        chk("stall_plus5", stall_cnt, 16'd6);
        chk("stall_in_ready", in_ready, 1'b0);
        chk("stall_payload", alu_out, 32'hCAFE_0001);

        // saturation of the narrow counter
        repeat (20) tick();
        chk("sat_c4", stall_cnt4, 4'd15);
        chk("nosat_c16", stall_cnt, 16'd26);

        // flush with a same-cycle input
        chk("pre_flush_m", m_out, 3'b101);
        flush = 1'b1; in_valid = 1'b1; alu_in = 32'h0000_DEAD;
        tick();
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_m", m_out, 3'b000);
        chk("flush_wb", wb_out, 2'b00);
        chk("flush_payload_kept", alu_out, 32'hCAFE_0001);
        chk("flush_keeps_stall", stall_cnt, 16'd27);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        got_en = 1'b1;
        repeat (3) tick();
        got_en = 1'b0;
        chk("flushed_never_out", got.size(), 0);
        got.delete();

        // back-to-back pushes with toggling downstream ready
        got_en = 1'b1; idx = 1; in_valid = 1'b1; alu_in = 32'd1;
        for (int c = 0; c < 20; c++) begin
            out_ready = (c % 2 == 1);
            tick();
            if (acc) begin
                idx++;
                if (idx > 3) in_valid = 1'b0;
                else alu_in = idx;
            end
        end
        got_en = 1'b0;
        chk("seq_len", got.size(), 3);
        for (int k = 0; k < 3; k++) begin
            chk("seq_order", (k < got.size()) ? got[k] : 32'hFFFF_FFFF, k + 1);
        end

        // randomized traffic with one mid-run reset
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ((i / 300) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            wb_in     = 2'($urandom);
            m_in      = 3'($urandom);
            data_in   = $urandom;
            alu_in    = $urandom;
            rdrt_in   = 5'($urandom);
            zero_in   = 1'($urandom);
            if (i == 1500) do_reset();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/exmem_stage_reg.md
EXMEM_STAGE_REG -- requirements
Module: exmem_stage_reg

Interface
REQ-001 The block SHALL have parameter WB_W, default 2, meaning writeback-control field width.
REQ-002 The block SHALL have parameter M_W, default 3, meaning memory-control field width.
REQ-003 The block SHALL have parameter DATA_W, default 32, meaning width of store-data and ALU-result fields.
REQ-004 The block SHALL have parameter RD_W, default 5, meaning destination-register field width.
REQ-005 The block SHALL have parameter CNT_W, default 16, meaning stall-counter width.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 in_valid  input  1  upstream (EX) entry present.
REQ-009 in_ready  output  1  stage can accept an entry this cycle.
REQ-010 wb_in, m_in, data_in, alu_in, rdrt_in, zero_in  input  WB_W, M_W, DATA_W, DATA_W, RD_W, 1  EX payload fields.
REQ-011 flush  input  1  discard all held entries and the same-cycle input.
REQ-012 out_valid  output  1  MEM-side entry present.
REQ-013 out_ready  input  1  downstream (MEM) accepts the entry.
REQ-014 wb_out, m_out, data_out, alu_out, rdrt_out, zero_out  output  widths as REQ-010  held payload.
REQ-015 stall_cnt  output  CNT_W  count of backpressure cycles.

Function
REQ-016 Transfer in SHALL occur on a rising edge where in_valid && in_ready && !flush; transfer out where out_valid && out_ready.
REQ-017 Input-to-output latency SHALL be exactly 1 cycle when the stage is empty and out_ready is high.
REQ-018 When out_valid is 0, wb_out and m_out SHALL be driven 0 (bubble: no write, no memory access); other outputs hold last value.
REQ-019 Payload fields SHALL be stored unmodified, bit-for-bit; entries SHALL leave in arrival order, none duplicated or dropped except by flush.
REQ-020 Simultaneous transfer in and out on a full single slot SHALL replace the slot with the new entry, out_valid staying 1.
REQ-021 flush SHALL on the next edge clear every valid bit, ignore the same-cycle input, and leave payload registers unchanged; flush has priority over all transfers.
REQ-022 stall_cnt SHALL increment by 1 on each edge where out_valid && !out_ready, saturate at all-ones, and not wrap.
REQ-023 flush SHALL NOT clear stall_cnt.

Reset
REQ-024 While rst is high, all valid bits, wb_out, m_out, data_out, alu_out, rdrt_out, zero_out and stall_cnt SHALL be 0 immediately, regardless of clk.
REQ-025 After rst deasserts, in_ready SHALL be 1 from the first edge; rst asserted mid-transfer discards the entry.

Configuration
REQ-026 Macro EXMEM_SKID_EN SHALL select the buffering mode.
REQ-027 Without EXMEM_SKID_EN: one slot; in_ready = !out_valid || out_ready (combinational from out_ready).
REQ-028 With EXMEM_SKID_EN: a main slot plus one skid slot; in_ready SHALL be a register equal to !skid_valid, with no combinational path from out_ready.
REQ-029 With EXMEM_SKID_EN, an entry accepted while main is valid and not leaving SHALL go to skid; when main leaves, skid SHALL move to main on the same edge, and a same-edge input SHALL go to the vacated slot in order.
REQ-030 With EXMEM_SKID_EN, flush SHALL clear both slots; reset SHALL clear both slots.

Verification
REQ-031 Empty stage, out_ready=1, push alu_in=0x0000_1234, wb_in=2'b11 -> next cycle out_valid=1, alu_out=0x0000_1234, wb_out=2'b11.
REQ-032 Full stage, out_ready=0 for 5 cycles -> stall_cnt increments by 5, payload stable, in_ready=0 (no skid) or 0 after one extra accept (skid).
REQ-033 Stage valid with m_out=3'b101, assert flush with in_valid=1 -> next cycle out_valid=0, m_out=0, wb_out=0; flushed input never appears.
REQ-034 CNT_W=4, hold out_ready=0 for 20 cycles -> stall_cnt stops at 15.
REQ-035 Assert rst between edges while out_valid=1 -> out_valid, all outputs and stall_cnt read 0 before the next edge.
REQ-036 EXMEM_SKID_EN defined, back-to-back pushes 1,2,3 with out_ready toggling 0,1,0,1 -> outputs 1,2,3 in order, none lost or repeated.
